// File: rtl/uart_rx_fsm_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm_if
//
// Bundles every non-clock, non-reset signal of the UART receive control FSM.
//
// Signals:
//   RX_IN        serial line (idle high), already synchronised
//   Prescale     oversampling ratio (8, 16 or 32)
//   PAR_EN       frame carries a parity bit
//   PAR_TYP      0 = even parity, 1 = odd parity
//   edge_cnt     oversample counter from edge_bit_counter
//   bit_cnt      bit counter from edge_bit_counter
//   sampled_bit  majority-voted bit from the data sampler
//   cnt_enable   enable for edge_bit_counter
//   dat_samp_en  enable for the data sampler
//   P_DATA       received byte
//   data_valid   one-cycle pulse, P_DATA is valid
//   par_err      sticky parity error
//   stp_err      sticky stop-bit error
//   strt_glitch  one-cycle pulse on a false start
//
// Modports:
//   slave  : the FSM itself
//   master : the surrounding receiver (counter, sampler, consumer)
// ---------------------------------------------------------------------------
interface uart_rx_fsm_if #(
  parameter int Prescale_width = 6
);
  logic                      RX_IN;
  logic [Prescale_width-1:0] Prescale;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [Prescale_width-1:0] edge_cnt;
  logic [3:0]                bit_cnt;
  logic                      sampled_bit;
  logic                      cnt_enable;
  logic                      dat_samp_en;
  logic [7:0]                P_DATA;
  logic                      data_valid;
  logic                      par_err;
  logic                      stp_err;
  logic                      strt_glitch;

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP, edge_cnt, bit_cnt, sampled_bit,
    output cnt_enable, dat_samp_en, P_DATA, data_valid, par_err, stp_err,
           strt_glitch
  );

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP, edge_cnt, bit_cnt, sampled_bit,
    input  cnt_enable, dat_samp_en, P_DATA, data_valid, par_err, stp_err,
           strt_glitch
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
//
// Control and checking stage of the UART receiver. Detects a start bit,
// enables the external edge/bit counter, walks through start, data, optional
// parity and stop bits using the counter values, shifts the sampled data bits
// into a byte (LSB first) and reports the byte with a one-cycle data_valid
// pulse. Parity and stop errors are sticky until the next frame starts; a
// start bit that samples high is reported as a one-cycle strt_glitch pulse.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      uart_rx_fsm_if.slave (see the interface header for the list)
//
// cnt_enable / dat_samp_en are decoded straight from the state register so
// they drop the moment reset is asserted; all other outputs are registered.
// ---------------------------------------------------------------------------
module uart_rx_fsm #(
  parameter int Prescale_width = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_rx_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [Prescale_width-1:0] PW_ONE = 1;
  localparam logic [Prescale_width-1:0] PW_TWO = 2;

  // Highest bit_cnt a legal frame can reach (stop bit of a parity frame).
  localparam logic [3:0] LAST_BIT = 4'd10;

  state_t     state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] p_data_reg, p_data_next;
  logic       data_valid_reg, data_valid_next;
  logic       par_err_reg, par_err_next;
  logic       stp_err_reg, stp_err_next;
  logic       strt_glitch_reg, strt_glitch_next;
  logic       par_en_reg, par_en_next;
  logic       par_typ_reg, par_typ_next;

  logic [Prescale_width-1:0] s_point;
  logic [Prescale_width-1:0] e_point;
  logic                      at_s;
  logic                      at_e;
  logic                      overrun;
  logic                      exp_parity;

  // Sample point sits two oversample ticks past mid-bit so the sampler's
  // majority window has completed; bit end is the counter's wrap value.
  assign s_point = (bus.Prescale >> 1) + PW_TWO;
  assign e_point = bus.Prescale - PW_ONE;
  assign at_s    = (bus.edge_cnt == s_point);
  assign at_e    = (bus.edge_cnt == e_point);

  // If Prescale is changed mid-frame the S/E points may never be hit; the
  // bit counter keeps advancing, so running past the last legal bit is used
  // as an escape back to IDLE.
  assign overrun = (bus.bit_cnt > LAST_BIT);

  assign exp_parity = (^shift_reg) ^ par_typ_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      p_data_reg      <= '0;
      data_valid_reg  <= 1'b0;
      par_err_reg     <= 1'b0;
      stp_err_reg     <= 1'b0;
      strt_glitch_reg <= 1'b0;
      par_en_reg      <= 1'b0;
      par_typ_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      p_data_reg      <= p_data_next;
      data_valid_reg  <= data_valid_next;
      par_err_reg     <= par_err_next;
      stp_err_reg     <= stp_err_next;
      strt_glitch_reg <= strt_glitch_next;
      par_en_reg      <= par_en_next;
      par_typ_reg     <= par_typ_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    shift_next       = shift_reg;
    p_data_next      = p_data_reg;
    data_valid_next  = 1'b0;
    par_err_next     = par_err_reg;
    stp_err_next     = stp_err_reg;
    strt_glitch_next = 1'b0;
    par_en_next      = par_en_reg;
    par_typ_next     = par_typ_reg;

    case (state_reg)
      IDLE: begin
        if (!bus.RX_IN) begin
          state_next   = START;
          par_en_next  = bus.PAR_EN;
          par_typ_next = bus.PAR_TYP;
          par_err_next = 1'b0;
          stp_err_next = 1'b0;
          shift_next   = '0;
        end
      end

      START: begin
        if (at_s && bus.sampled_bit) begin
          strt_glitch_next = 1'b1;
          state_next       = IDLE;
        end else if (at_e && (bus.bit_cnt == 4'd0)) begin
          state_next = DATA;
        end else if (bus.bit_cnt != 4'd0) begin
          // Start bit end was skipped (Prescale disturbed): abandon frame.
          state_next = IDLE;
        end
      end

      DATA: begin
        if (at_s) begin
          shift_next = {bus.sampled_bit, shift_reg[7:1]};
        end
        if (at_e && (bus.bit_cnt == 4'd8)) begin
          state_next = par_en_reg ? PARITY : STOP;
        end
      end

      PARITY: begin
        if (at_s && (bus.sampled_bit != exp_parity)) begin
          par_err_next = 1'b1;
        end
        if (at_e) begin
          state_next = STOP;
        end
      end

      STOP: begin
        if (at_s) begin
          state_next = IDLE;
          if (!bus.sampled_bit) begin
            stp_err_next = 1'b1;
          end else if (!par_err_reg) begin
            p_data_next     = shift_reg;
            data_valid_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if ((state_reg != IDLE) && overrun) begin
      state_next = IDLE;
    end
  end

  assign bus.cnt_enable  = (state_reg != IDLE);
  assign bus.dat_samp_en = (state_reg != IDLE);
  assign bus.P_DATA      = p_data_reg;
  assign bus.data_valid  = data_valid_reg;
  assign bus.par_err     = par_err_reg;
  assign bus.stp_err     = stp_err_reg;
  assign bus.strt_glitch = strt_glitch_reg;

endmodule
